// File: rtl/multiplier_issue_collect_tt_pkg.sv
// Shared encodings for the taint-tracked multiplier issue/collect stage.
package multiplier_issue_collect_tt_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      HOLD  = 2'd3
   } state_e;

   localparam int DEFAULT_DONE_GUARD = 1;

endpackage

// File: rtl/multiplier_issue_collect_tt_sat_counter.sv
// Saturating up-counter with clear/enable and a sticky value taint.
// Single-cycle update; clear has priority over enable; holds at all-ones.
module multiplier_issue_collect_tt_sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clr,
   input  logic             i_clr_t,
   input  logic             i_en,
   input  logic             i_en_t,
   output logic [CNT_W-1:0] o_val,
   output logic             o_val_t,
   output logic             o_sat
);

   logic [CNT_W-1:0] r_val;
   logic             r_val_t;
   logic             w_sat;

   assign w_sat = &r_val;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_val   <= '0;
         r_val_t <= 1'b0;
      end else begin
         if (i_clr) begin
            r_val <= '0;
         end else if (i_en && !w_sat) begin
            r_val <= r_val + CNT_W'(1);
         end
         // A tainted decision not to clear/count still leaks, so taint is unconditional.
         r_val_t <= r_val_t | i_clr_t | i_en_t;
      end
   end

   assign o_val   = r_val;
   assign o_val_t = r_val_t;
   assign o_sat   = w_sat;

endmodule

// File: rtl/multiplier_issue_collect_tt.sv
// Issue/collect stage around a taint-tracking multiplier: one operand pair in flight,
// result held in HOLD until out_ready; every output carries a shadow taint.
module multiplier_issue_collect_tt
   import multiplier_issue_collect_tt_pkg::*;
#(
   parameter int WIDTH      = 512,
   parameter int CNT_W      = 16,
   parameter int DONE_GUARD = DEFAULT_DONE_GUARD
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic               in_valid_t,
   output logic               in_ready,
   output logic               in_ready_t,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_a_t,
   input  logic [WIDTH-1:0]   in_b,
   input  logic [WIDTH-1:0]   in_b_t,
   output logic               mul_start,
   output logic               mul_start_t,
   output logic [WIDTH-1:0]   mul_multiplier,
   output logic [WIDTH-1:0]   mul_multiplier_t,
   output logic [WIDTH-1:0]   mul_multiplicand,
   output logic [WIDTH-1:0]   mul_multiplicand_t,
   input  logic [2*WIDTH-1:0] mul_product,
   input  logic [2*WIDTH-1:0] mul_product_t,
   input  logic               mul_done,
   input  logic               mul_done_t,
   output logic               out_valid,
   output logic               out_valid_t,
   input  logic               out_ready,
   input  logic               out_ready_t,
   output logic [2*WIDTH-1:0] out_product,
   output logic [2*WIDTH-1:0] out_product_t,
   output logic [CNT_W-1:0]   out_cycles,
   output logic [CNT_W-1:0]   out_cycles_t
);

   localparam int GUARD_W = (DONE_GUARD < 1) ? 1 : $clog2(DONE_GUARD + 1);

   state_e               r_state;
   state_e               w_state_nxt;
   logic                 r_ctrl_t;
   logic                 w_ctrl_t;
   logic                 w_accept;
   logic                 w_capture;
   logic                 w_guard_zero;
   logic [GUARD_W-1:0]   r_guard;
   logic [WIDTH-1:0]     r_a;
   logic [WIDTH-1:0]     r_a_t;
   logic [WIDTH-1:0]     r_b;
   logic [WIDTH-1:0]     r_b_t;
   logic [2*WIDTH-1:0]   r_prod;
   logic [2*WIDTH-1:0]   r_prod_t;
   logic [CNT_W-1:0]     r_cycles;
   logic [CNT_W-1:0]     r_cycles_t;
   logic [CNT_W-1:0]     w_cnt;
   logic                 w_cnt_t;
   logic                 w_cnt_sat;

   assign w_guard_zero = (r_guard == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // w_ctrl_t folds in the taint of whichever control input this cycle's decision samples.
   always_comb begin
      w_state_nxt = r_state;
      w_ctrl_t    = r_ctrl_t;
      w_accept    = 1'b0;
      w_capture   = 1'b0;
      in_ready    = 1'b0;
      mul_start   = 1'b0;
      out_valid   = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            w_ctrl_t = r_ctrl_t | in_valid_t;
            if (in_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = START;
            end
         end
         START: begin
            mul_start   = 1'b1;
            w_state_nxt = WAIT;
         end
         WAIT: begin
            if (w_guard_zero) begin
               w_ctrl_t = r_ctrl_t | mul_done_t;
               if (mul_done) begin
                  w_capture   = 1'b1;
                  w_state_nxt = HOLD;
               end
            end
         end
         HOLD: begin
            out_valid = 1'b1;
            w_ctrl_t  = r_ctrl_t | out_ready_t;
            if (out_ready) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ctrl_t   <= 1'b0;
         r_guard    <= '0;
         r_a        <= '0;
         r_a_t      <= '0;
         r_b        <= '0;
         r_b_t      <= '0;
         r_prod     <= '0;
         r_prod_t   <= '0;
         r_cycles   <= '0;
         r_cycles_t <= '0;
      end else begin
         r_ctrl_t <= w_ctrl_t;
         if (w_accept) begin
            r_a   <= in_a;
            r_a_t <= in_a_t;
            r_b   <= in_b;
            r_b_t <= in_b_t;
         end
         if (r_state == START) begin
            r_guard <= GUARD_W'(DONE_GUARD);
         end else if (r_state == WAIT && !w_guard_zero) begin
            r_guard <= r_guard - GUARD_W'(1);
         end
         if (w_capture) begin
            r_prod     <= mul_product;
            r_prod_t   <= mul_product_t;
            r_cycles   <= w_cnt_sat ? w_cnt : w_cnt + CNT_W'(1);
            r_cycles_t <= {CNT_W{w_ctrl_t | w_cnt_t}};
         end
      end
   end

   multiplier_issue_collect_tt_sat_counter #(
      .CNT_W (CNT_W)
   ) u_cycle_cnt (
      .clk     (clk),
      .rst     (rst),
      .i_clr   (r_state == START),
      .i_clr_t (r_ctrl_t),
      .i_en    (r_state == WAIT),
      .i_en_t  (r_ctrl_t),
      .o_val   (w_cnt),
      .o_val_t (w_cnt_t),
      .o_sat   (w_cnt_sat)
   );

   assign in_ready_t         = w_ctrl_t;
   assign mul_start_t        = w_ctrl_t;
   assign out_valid_t        = w_ctrl_t;
   assign mul_multiplier     = r_a;
   assign mul_multiplier_t   = r_a_t;
   assign mul_multiplicand   = r_b;
   assign mul_multiplicand_t = r_b_t;
   assign out_product        = r_prod;
   assign out_product_t      = r_prod_t;
   assign out_cycles         = r_cycles;
   assign out_cycles_t       = r_cycles_t;

endmodule

// File: tb/tb_multiplier_issue_collect_tt.sv
// Directed bench for multiplier_issue_collect_tt with a transaction-level reference model
// compared every cycle, plus literal expectations at key points.
module tb_multiplier_issue_collect_tt;

   localparam int W = 8;
   localparam int C = 8;
   localparam int G = 1;

   logic           clk = 1'b0;
   logic           rst;
   logic           in_valid, in_valid_t, in_ready, in_ready_t;
   logic [W-1:0]   in_a, in_a_t, in_b, in_b_t;
   logic           mul_start, mul_start_t;
   logic [W-1:0]   mul_multiplier, mul_multiplier_t, mul_multiplicand, mul_multiplicand_t;
   logic [2*W-1:0] mul_product, mul_product_t;
   logic           mul_done, mul_done_t;
   logic           out_valid, out_valid_t, out_ready, out_ready_t;
   logic [2*W-1:0] out_product, out_product_t;
   logic [C-1:0]   out_cycles, out_cycles_t;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   multiplier_issue_collect_tt #(.WIDTH(W), .CNT_W(C), .DONE_GUARD(G)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_valid_t(in_valid_t), .in_ready(in_ready), .in_ready_t(in_ready_t),
      .in_a(in_a), .in_a_t(in_a_t), .in_b(in_b), .in_b_t(in_b_t),
      .mul_start(mul_start), .mul_start_t(mul_start_t),
      .mul_multiplier(mul_multiplier), .mul_multiplier_t(mul_multiplier_t),
      .mul_multiplicand(mul_multiplicand), .mul_multiplicand_t(mul_multiplicand_t),
      .mul_product(mul_product), .mul_product_t(mul_product_t),
      .mul_done(mul_done), .mul_done_t(mul_done_t),
      .out_valid(out_valid), .out_valid_t(out_valid_t),
      .out_ready(out_ready), .out_ready_t(out_ready_t),
      .out_product(out_product), .out_product_t(out_product_t),
      .out_cycles(out_cycles), .out_cycles_t(out_cycles_t)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: busy/holding flags plus cycles elapsed since the start pulse.
   bit             m_ok = 1'b0;
   bit             m_idle, m_hold, m_ctrl, m_c;
   int             m_since;
   logic [W-1:0]   m_a, m_at, m_b, m_bt;
   logic [2*W-1:0] m_p, m_pt;
   logic [C-1:0]   m_cyc, m_cyct;

   function automatic logic ctrl_now();
      return m_ctrl | (m_idle & in_valid_t)
           | (!m_idle && !m_hold && m_since >= 1 + G && mul_done_t)
           | (m_hold & out_ready_t);
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_ok = 1'b1; m_idle = 1'b1; m_hold = 1'b0; m_ctrl = 1'b0; m_since = 0;
         m_a = '0; m_at = '0; m_b = '0; m_bt = '0;
         m_p = '0; m_pt = '0; m_cyc = '0; m_cyct = '0;
      end else if (m_ok) begin
         m_c = ctrl_now();
         if (m_idle) begin
            if (in_valid) begin
               m_a = in_a; m_at = in_a_t; m_b = in_b; m_bt = in_b_t;
               m_idle = 1'b0; m_since = 0;
            end
         end else if (m_hold) begin
            if (out_ready) begin
               m_hold = 1'b0; m_idle = 1'b1;
            end
         end else if (m_since >= 1 + G && mul_done) begin
            m_p = mul_product; m_pt = mul_product_t;
            m_cyc = C'((m_since > 255) ? 255 : m_since);
            m_cyct = {C{m_c}};
            m_hold = 1'b1;
         end else begin
            m_since++;
         end
         m_ctrl = m_c;
      end
   end

   always @(negedge clk) begin
      if (m_ok) begin
         chk("in_ready", in_ready, m_idle);
         chk("mul_start", mul_start, !m_idle && !m_hold && m_since == 0);
         chk("out_valid", out_valid, m_hold);
         chk("in_ready_t", in_ready_t, ctrl_now());
         chk("mul_start_t", mul_start_t, ctrl_now());
         chk("out_valid_t", out_valid_t, ctrl_now());
         chk("mul_multiplier", mul_multiplier, m_a);
         chk("mul_multiplier_t", mul_multiplier_t, m_at);
         chk("mul_multiplicand", mul_multiplicand, m_b);
         chk("mul_multiplicand_t", mul_multiplicand_t, m_bt);
         chk("out_product", out_product, m_p);
         chk("out_product_t", out_product_t, m_pt);
         chk("out_cycles", out_cycles, m_cyc);
         chk("out_cycles_t", out_cycles_t, m_cyct);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [W-1:0] a, at, b, bt);
      int n = 0;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL wait_in_ready: got 0 expected 1 within 50 cycles");
      end
      in_valid = 1'b1; in_a = a; in_a_t = at; in_b = b; in_b_t = bt;
      tick();
      in_valid = 1'b0; in_a_t = '0; in_b_t = '0;
      chk("start_pulse", mul_start, 1'b1);
   endtask

   task automatic done_after(input int k, input logic [2*W-1:0] p, pt, input logic dt);
      repeat (k) tick();
      mul_done = 1'b1; mul_product = p; mul_product_t = pt; mul_done_t = dt;
      tick();
      mul_done = 1'b0; mul_done_t = 1'b0; mul_product_t = '0;
   endtask

   task automatic drain(input int n);
      repeat (n) tick();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      in_valid = 1'b0; in_valid_t = 1'b0; in_a = '0; in_a_t = '0; in_b = '0; in_b_t = '0;
      mul_product = '0; mul_product_t = '0; mul_done = 1'b0; mul_done_t = 1'b0;
      out_ready = 1'b0; out_ready_t = 1'b0;
      tick(); tick();
      rst = 1'b0;
      chk("reset_in_ready", in_ready, 1'b1);
      chk("reset_out_valid", out_valid, 1'b0);
      chk("reset_mul_start", mul_start, 1'b0);
      chk("reset_in_ready_t", in_ready_t, 1'b0);
      chk("reset_out_product", out_product, 16'h0000);

      // Basic: 0x0D * 0x0B, done 9 cycles after start
      issue(8'h0D, 8'h00, 8'h0B, 8'h00);
      done_after(9, 16'h008F, 16'h0000, 1'b0);
      chk("basic_out_valid", out_valid, 1'b1);
      chk("basic_product", out_product, 16'h008F);
      chk("basic_cycles", out_cycles, 8'd9);
      chk("basic_operand", mul_multiplier, 8'h0D);
      chk("basic_taint", {out_valid_t, out_product_t, out_cycles_t}, 25'h0);
      drain(2);
      chk("basic_released", out_valid, 1'b0);

      // Stale done held from before start
      mul_done = 1'b1; mul_product = 16'h0042;
      issue(8'h03, 8'h00, 8'h05, 8'h00);
      tick();
      chk("stale_guard", out_valid, 1'b0);
      tick();
      chk("stale_not_yet", out_valid, 1'b0);
      tick();
      mul_done = 1'b0;
      chk("stale_valid", out_valid, 1'b1);
      chk("stale_cycles", out_cycles, 8'd2);
      chk("stale_product", out_product, 16'h0042);
      drain(0);

      // Backpressure, then in_valid overlapping the release handshake
      issue(8'h07, 8'h00, 8'h06, 8'h00);
      done_after(3, 16'h002A, 16'h0000, 1'b0);
      for (int i = 0; i < 5; i++) begin
         chk("bp_in_ready", in_ready, 1'b0);
         chk("bp_product", out_product, 16'h002A);
         chk("bp_cycles", out_cycles, 8'd3);
         tick();
      end
      in_valid = 1'b1; in_a = 8'h02; in_b = 8'h03; out_ready = 1'b1;
      chk("bp_handshake_in_ready", in_ready, 1'b0);
      tick();
      out_ready = 1'b0;
      chk("bp_idle_in_ready", in_ready, 1'b1);
      chk("bp_no_bypass", mul_start, 1'b0);
      tick();
      in_valid = 1'b0;
      chk("bp_next_start", mul_start, 1'b1);
      chk("bp_next_operand", mul_multiplier, 8'h02);
      done_after(4, 16'h0006, 16'h0000, 1'b0);
      drain(0);

      // Saturation
      issue(8'hFF, 8'h00, 8'hFF, 8'h00);
      repeat (300) tick();
      chk("sat_no_done", out_valid, 1'b0);
      done_after(0, 16'hFE01, 16'h0000, 1'b0);
      chk("sat_cycles", out_cycles, 8'hFF);
      chk("sat_product", out_product, 16'hFE01);
      drain(1);

      // Taint: data taints copy, then tainted done poisons control
      issue(8'h05, 8'h01, 8'h04, 8'h00);
      chk("taint_operand", mul_multiplier_t, 8'h01);
      done_after(5, 16'h0014, 16'h0003, 1'b0);
      chk("taint_product", out_product_t, 16'h0003);
      chk("taint_valid_clean", out_valid_t, 1'b0);
      chk("taint_cycles_clean", out_cycles_t, 8'h00);
      drain(0);
      issue(8'h02, 8'h00, 8'h02, 8'h00);
      done_after(3, 16'h0004, 16'h0000, 1'b1);
      chk("taint_valid_t", out_valid_t, 1'b1);
      chk("taint_cycles_t", out_cycles_t, 8'hFF);
      drain(0);
      chk("taint_sticky_ready", in_ready_t, 1'b1);
      issue(8'h01, 8'h00, 8'h01, 8'h00);
      chk("taint_sticky_start", mul_start_t, 1'b1);

      // Reset in the middle of WAIT
      tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_ctrl_t", in_ready_t, 1'b0);
      chk("rst_data_t", {mul_multiplier_t, out_product_t, out_cycles_t}, 32'h0);
      issue(8'h0C, 8'h00, 8'h0A, 8'h00);
      done_after(4, 16'h0078, 16'h0000, 1'b0);
      chk("post_rst_product", out_product, 16'h0078);
      chk("post_rst_cycles", out_cycles, 8'd4);
      chk("post_rst_taint", out_valid_t, 1'b0);
      drain(1);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/multiplier_issue_collect_tt.md
Name: multiplier_issue_collect_tt

Overview:
- Taint-tracked issue/collect stage wrapped around the taint-tracking multiplier.
- Upstream side: accepts operand pairs over a valid/ready handshake, holds them stable, and pulses the multiplier start.
- Downstream side: waits for the done flag, captures product plus taint, and presents the result with a measured cycle count (for constant-time checking) over a valid/ready handshake.
- Every data and control output carries a shadow taint signal.

Parameters:
- WIDTH, 512, operand width; product is 2*WIDTH.
- CNT_W, 16, width of the start-to-done cycle counter.
- DONE_GUARD, 1, cycles after start during which mul_done is ignored; must be >= 1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid / in_valid_t  in  1  operand pair valid / taint.
- in_ready / in_ready_t  out  1  stage accepts operands / taint.
- in_a / in_a_t  in  WIDTH  multiplier operand / taint.
- in_b / in_b_t  in  WIDTH  multiplicand operand / taint.
- mul_start / mul_start_t  out  1  one-cycle start pulse to multiplier / taint.
- mul_multiplier / mul_multiplier_t  out  WIDTH  held operand A / taint.
- mul_multiplicand / mul_multiplicand_t  out  WIDTH  held operand B / taint.
- mul_product / mul_product_t  in  2*WIDTH  multiplier product / taint.
- mul_done / mul_done_t  in  1  multiplier done / taint.
- out_valid / out_valid_t  out  1  result valid / taint.
- out_ready / out_ready_t  in  1  consumer ready / taint.
- out_product / out_product_t  out  2*WIDTH  captured product / taint.
- out_cycles / out_cycles_t  out  CNT_W  cycles from start pulse to accepted done / taint.

Behaviour:
- Reset: all registers cleared in one cycle regardless of state; in-flight operation is abandoned.
  - After reset: state=IDLE; in_ready=1; mul_start=0; out_valid=0; product, operand, count and all taint registers = 0.
- States: IDLE, START, WAIT, HOLD; 2-bit encoding.
- IDLE:
  - in_ready=1.
  - On in_valid=1: latch in_a/in_b and their taints into operand registers, then go to START.
- START:
  - mul_start=1 for exactly this one cycle; cycle counter cleared to 0.
  - Next state: WAIT, with guard counter loaded to DONE_GUARD.
- WAIT:
  - Cycle counter increments every cycle and saturates at 2^CNT_W-1 (no wrap).
  - mul_done is ignored while the guard counter is nonzero; guard decrements each cycle.
  - When guard==0 and mul_done=1:
    - capture mul_product into out_product and mul_product_t into out_product_t;
    - out_cycles = counter + 1;
    - go to HOLD.
- HOLD:
  - out_valid=1; outputs are stable.
  - On out_ready=1: go to IDLE. No bypass: a new operand is accepted no earlier than the cycle after the HOLD handshake.
- Operand stability: mul_multiplier and mul_multiplicand are driven from the operand registers and are unchanged from START through HOLD.
- in_ready is 1 only in IDLE, so simultaneous in_valid with out_ready cannot overlap.
- Taint rules (conservative):
  - Data taints copy bitwise alongside their data.
  - ctrl_t is a sticky bit, set when a transition decision samples a tainted control input:
    - in_valid_t in IDLE;
    - mul_done_t in WAIT with guard==0;
    - out_ready_t in HOLD.
  - ctrl_t clears only on reset.
  - in_ready_t, mul_start_t and out_valid_t each equal ctrl_t, where ctrl_t includes any taint sampled in the same cycle's decision.
  - out_cycles_t: all bits = ctrl_t at the moment of capture; the latency is secret-dependent if the control is.
- Untainted inputs with ctrl_t=0 give all-zero output taints.

Decomposition:
- Shared package holds:
  - state encoding constants IDLE=0, START=1, WAIT=2, HOLD=3;
  - the default DONE_GUARD.
- One natural sub-module: tt_sat_counter, a CNT_W saturating counter with clear/enable and taint propagation (value taint = OR of clear/enable taints, sticky). It is reused for the cycle counter; the guard counter stays inline.

Test Plan:
- All tests use WIDTH=8, CNT_W=8, DONE_GUARD=1.
- Basic: in_a=0x0D, in_b=0x0B, model done 9 cycles after start with product 0x008F -> single mul_start pulse, out_product=0x008F, out_cycles=9, out_valid held until out_ready, all taints 0.
- Stale done: mul_done held 1 from before start -> not captured in guard cycle; capture occurs only on a done at guard==0, with out_cycles >= 2.
- Backpressure: out_ready=0 for 5 cycles in HOLD -> outputs stable, in_ready=0 throughout; in_valid in the handshake cycle is accepted only the next cycle.
- Taint: in_a_t=0x01, mul_product_t=0x0003 -> mul_multiplier_t=0x01, out_product_t=0x0003, out_valid_t=0; then mul_done_t=1 at capture -> out_valid_t=1, out_cycles_t=0xFF, and ctrl_t remains set on the next transaction.
- Saturation: done never asserted for 300 cycles -> out_cycles counter stops at 0xFF and does not wrap; late done then captures with out_cycles=0xFF.
- Reset mid-WAIT: rst=1 one cycle -> next cycle state=IDLE, in_ready=1, out_valid=0, all taints 0; a subsequent transaction completes normally.
